id_hazard_ctrl: RTL and testbench
=================================

Name: id_hazard_ctrl

Overview:
- Sequencing controller for the ID stage of the 5-stage MIPS pipeline.
- Decodes the instruction in ID and keeps a 3-entry scoreboard of in-flight destinations (EX, MEM, WB).
- Drives the ID forwarding mux selects, PC source select, sign-extend control, stall/bubble and IF flush.
- Owns all load-use and branch-operand hazard resolution for the pipeline.

Parameters:
- REG_ADDR_W, 5, register address width.
- LINK_REG, 31, destination written by jal.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_id  in  32  instruction currently in IF/ID.
- valid_id  in  1  IF/ID holds a real instruction.
- cmp_eq  in  1  ID comparator result (forwarded rs == forwarded rt).
- forbranchA  out  2  rs operand select: 00 regfile, 01 writeData (WB), 10 exOut (MEM), 11 unused.
- forbranchB  out  2  rt operand select, same encoding.
- PCsrc  out  2  00 pc+4, 01 jump target, 10 branch target, 11 forwarded rs (jr).
- signExtendControl  out  1  1 sign-extend, 0 zero-extend.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID update enable.
- idex_bubble  out  1  inject NOP into ID/EX.
- flush_if  out  1  squash the instruction being fetched.

Behaviour:
- Decode:
  - rs = inst[25:21], rt = inst[20:16], rd = inst[15:11].
  - Reads rs: all except j(2) and jal(3).
  - Reads rt: R-type, beq(4), bne(5), sw(43).
  - Destination: R-type except jr (funct 8) -> rd; op 8..15 and lw(35) -> rt; jal -> LINK_REG; otherwise none.
  - Destination 0 is always "none".
- Scoreboard:
  - Three entries {v, dst, ld}: EX, MEM, WB, all registered.
  - Each clock: WB<=MEM, MEM<=EX.
  - EX <= ID decode if the ID instruction is effective and not stalled; otherwise EX <= invalid.
- Effective ID: valid_id && !kill_q.
  - kill_q is a register set for one cycle after a cycle with flush_if=1.
  - kill_q masks the squashed slot without relying on IF/ID clearing.
- Hazard match:
  - Applies to a source register that is read, nonzero, and equals a valid entry's dst.
  - The youngest matching entry wins (EX > MEM > WB).
- Branch/jr operand (beq, bne, jr):
  - Match in EX -> stall.
  - Match in MEM with ld=1 -> stall.
  - Match in MEM with ld=0 -> select 10.
  - Match in WB -> select 01.
  - No match -> select 00.
- Non-branch operand:
  - Stall only if the EX entry has ld=1 and matches (load-use); otherwise select 00 (EX-stage forwarding is handled downstream).
- Stall (combinational):
  - pc_write=0, ifid_write=0, idex_bubble=1, flush_if=0, PCsrc=00.
- No stall:
  - pc_write=1, ifid_write=1, idex_bubble=0.
  - PCsrc: j/jal -> 01; beq with cmp_eq=1 or bne with cmp_eq=0 -> 10; jr -> 11; else 00.
  - flush_if = (PCsrc != 00).
- Resulting penalties:
  - ALU result feeding a branch: 1 stall.
  - lw feeding a branch: 2 stalls.
  - lw feeding an ALU op: 1 stall.
- Non-effective ID: no stall, PCsrc=00, flush_if=0, and forbranchA/B=00.
- signExtendControl: 0 for op 12, 13, 14 (andi/ori/xori); 1 otherwise. Combinational and independent of stall.
- Reset:
  - Asynchronously clears all scoreboard entries and kill_q.
  - During reset, outputs are forced to pc_write=1, ifid_write=1, idex_bubble=0, flush_if=0, PCsrc=00, forbranchA/B=00.
  - Reset mid-stall drops the stall immediately, since no hazards remain.
- Simultaneous events:
  - A stall has priority over branch/jump resolution; the branch resolves in the first non-stalled cycle.
  - A jump while kill_q=1 is ignored (squashed slot).

Optional Feature:
- Macro HAZARD_STATS_EN adds two outputs:
  - stall_cnt[15:0]: counts cycles with idex_bubble=1.
  - flush_cnt[15:0]: counts cycles with flush_if=1.
- Both counters saturate at 16'hFFFF and are cleared by reset.
- Without the macro these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- add $3,$1,$2 then beq $3,$4 with cmp_eq=1:
  - cycle 1: idex_bubble=1, pc_write=0.
  - cycle 2: forbranchA=10, PCsrc=10, flush_if=1.
  - cycle 3: kill_q masks ID, so PCsrc=00.
- lw $5,0($1) then bne $5,$0 with cmp_eq=0:
  - two stall cycles.
  - third cycle: forbranchA=01, forbranchB=00, PCsrc=10.
- lw $7 then add $8,$7,$7:
  - exactly 1 stall cycle.
  - then forbranchA/B=00 and no further stall.
- j 0x0000040 with no hazards -> PCsrc=01 and flush_if=1 in the same cycle; next-cycle EX entry invalid.
- jal then jr $31 three instructions later -> forbranchA=01 (WB match) and PCsrc=11; ori decoded gives signExtendControl=0.
- Reset asserted during a load-use stall -> idex_bubble=0 and pc_write=1 immediately; scoreboard empty; an add with rs=$0 never stalls.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - ID-stage decode, in-flight destination scoreboard and hazard/branch sequencing
// Optional macro HAZARD_STATS_EN adds saturating stall_cnt/flush_cnt outputs.
module id_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int LINK_REG   = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst_id,
    input  logic        valid_id,
    input  logic        cmp_eq,
    output logic [1:0]  forbranchA,
    output logic [1:0]  forbranchB,
    output logic [1:0]  PCsrc,
    output logic        signExtendControl,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_bubble,
`ifdef HAZARD_STATS_EN
    output logic        flush_if,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`else
    output logic        flush_if
`endif
);

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] dst;
        logic                  ld;
    } sb_t;

    sb_t ex_q, mem_q, wb_q, dec;
    logic kill_q;

    logic [5:0]            op;
    logic [5:0]            funct;
    logic [REG_ADDR_W-1:0] rs, rt, rd;
    logic                  is_jr, is_br, reads_rs, reads_rt, eff, stall;
    logic [2:0]            res_a, res_b;
    logic                  unused_bits;

    assign op          = inst_id[31:26];
    assign funct       = inst_id[5:0];
    assign rs          = REG_ADDR_W'(inst_id[25:21]);
    assign rt          = REG_ADDR_W'(inst_id[20:16]);
    assign rd          = REG_ADDR_W'(inst_id[15:11]);
    assign unused_bits = ^inst_id[10:6];

    assign is_jr    = (op == 6'd0) && (funct == 6'd8);
    assign is_br    = (op == 6'd4) || (op == 6'd5) || is_jr;
    assign reads_rs = !((op == 6'd2) || (op == 6'd3));
    assign reads_rt = (op == 6'd0) || (op == 6'd4) || (op == 6'd5) || (op == 6'd43);
    assign eff      = valid_id && !kill_q;

    assign signExtendControl = !((op == 6'd12) || (op == 6'd13) || (op == 6'd14));

    always_comb begin
        dec = '0;
        if (op == 6'd0) begin
            if (!is_jr) dec.dst = rd;
        end else if (((op >= 6'd8) && (op <= 6'd15)) || (op == 6'd35)) begin
            dec.dst = rt;
            dec.ld  = (op == 6'd35);
        end else if (op == 6'd3) begin
            dec.dst = REG_ADDR_W'(LINK_REG);
        end
        dec.v = (dec.dst != '0);
    end

    // Returns {stall, select}; youngest matching entry decides.
    function automatic logic [2:0] resolve(input logic rd_en, input logic [REG_ADDR_W-1:0] src,
                                           input logic br, input sb_t ex, input sb_t mem,
                                           input sb_t wb);
        logic hit_ex, hit_mem, hit_wb;
        hit_ex  = rd_en && (src != '0) && ex.v  && (ex.dst  == src);
        hit_mem = rd_en && (src != '0) && mem.v && (mem.dst == src);
        hit_wb  = rd_en && (src != '0) && wb.v  && (wb.dst  == src);
        resolve = 3'b000;
        if (br) begin
            if (hit_ex)       resolve = 3'b100;
            else if (hit_mem) resolve = mem.ld ? 3'b100 : 3'b010;
            else if (hit_wb)  resolve = 3'b001;
        end else if (hit_ex && ex.ld) begin
            resolve = 3'b100;
        end
    endfunction

    assign res_a = resolve(reads_rs, rs, is_br, ex_q, mem_q, wb_q);
    assign res_b = resolve(reads_rt, rt, is_br, ex_q, mem_q, wb_q);

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        flush_if    = 1'b0;
        PCsrc       = 2'b00;
        forbranchA  = 2'b00;
        forbranchB  = 2'b00;
        stall       = 1'b0;
        if (!reset && eff) begin
            stall = res_a[2] || res_b[2];
            if (stall) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end else begin
                forbranchA = res_a[1:0];
                forbranchB = res_b[1:0];
                if ((op == 6'd2) || (op == 6'd3))       PCsrc = 2'b01;
                else if ((op == 6'd4) && cmp_eq)        PCsrc = 2'b10;
                else if ((op == 6'd5) && !cmp_eq)       PCsrc = 2'b10;
                else if (is_jr)                         PCsrc = 2'b11;
                flush_if = (PCsrc != 2'b00);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q   <= '0;
            mem_q  <= '0;
            wb_q   <= '0;
            kill_q <= 1'b0;
        end else begin
            wb_q   <= mem_q;
            mem_q  <= ex_q;
            ex_q   <= (eff && !stall) ? dec : '0;
            kill_q <= flush_if;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (idex_bubble && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
            if (flush_if && (flush_cnt != 16'hFFFF))    flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb/tb_id_hazard_ctrl.sv - directed vector table plus randomized reference-model check of id_hazard_ctrl
module tb_id_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] inst_id = '0;
    logic        valid_id = 1'b0;
    logic        cmp_eq = 1'b0;
    logic [1:0]  forbranchA, forbranchB, PCsrc;
    logic        signExtendControl, pc_write, ifid_write, idex_bubble, flush_if;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_hazard_ctrl dut (
        .clk(clk), .reset(reset), .inst_id(inst_id), .valid_id(valid_id), .cmp_eq(cmp_eq),
        .forbranchA(forbranchA), .forbranchB(forbranchB), .PCsrc(PCsrc),
        .signExtendControl(signExtendControl), .pc_write(pc_write), .ifid_write(ifid_write),
        .idex_bubble(idex_bubble),
`ifdef HAZARD_STATS_EN
        .flush_if(flush_if), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`else
        .flush_if(flush_if)
`endif
    );

    typedef struct {
        logic        rst;
        logic        v;
        logic [31:0] inst;
        logic        eq;
        logic        st;
        logic [1:0]  pcs;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        se;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic rst, input logic v, input logic [31:0] inst,
                                input logic eq, input logic st, input logic [1:0] pcs,
                                input logic [1:0] fa, input logic [1:0] fb, input logic se);
        vec_t r;
        r.rst = rst; r.v = v; r.inst = inst; r.eq = eq; r.st = st;
        r.pcs = pcs; r.fa = fa; r.fb = fb; r.se = se;
        return r;
    endfunction

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] jtype(input int op, input int tgt);
        return {6'(op), 26'(tgt)};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ctl_exp(input logic st, input logic [1:0] pcs, input logic se);
        return {9'd0, !st, !st, st, (pcs != 2'b00), pcs, se};
    endfunction

    function automatic logic [15:0] ctl_act();
        return {9'd0, pc_write, ifid_write, idex_bubble, flush_if, PCsrc, signExtendControl};
    endfunction

    // Reference model: destinations issued 1, 2 and 3 cycles ago (0 = nothing).
    logic [4:0] h_dst[3];
    bit         h_ld[3];
    bit         kill_m;

    function automatic void mdec(input logic [31:0] ins, output bit rrs, output bit rrt,
                                 output bit br, output bit ld, output logic [4:0] dst);
        int op = int'(ins[31:26]);
        int fn = int'(ins[5:0]);
        rrs = !(op == 2 || op == 3);
        rrt = (op == 0 || op == 4 || op == 5 || op == 43);
        br  = (op == 4 || op == 5 || (op == 0 && fn == 8));
        ld  = (op == 35);
        if (op == 0)                          dst = (fn == 8) ? 5'd0 : ins[15:11];
        else if ((op >= 8 && op <= 15) || op == 35) dst = ins[20:16];
        else if (op == 3)                     dst = 5'd31;
        else                                  dst = 5'd0;
    endfunction

    // A producer at distance 'age' is usable by a branch once age >= 2 (ALU) or 3 (load).
    function automatic void mop(input bit rd, input logic [4:0] src, input bit br,
                                output bit st, output logic [1:0] sel);
        int age = 0;
        int need;
        st = 0;
        sel = 2'b00;
        for (int a = 0; a < 3; a++)
            if (age == 0 && rd && src != 5'd0 && h_dst[a] == src) age = a + 1;
        if (age != 0) begin
            if (br) begin
                need = h_ld[age-1] ? 3 : 2;
                if (age < need) st = 1;
                else sel = (age == 2) ? 2'b10 : 2'b01;
            end else begin
                st = (age == 1) && h_ld[0];
            end
        end
    endfunction

    function automatic int rreg();
        int r = int'($urandom_range(0, 5));
        return (r == 5) ? 31 : r;
    endfunction

    function automatic logic [31:0] rnd_inst();
        int sel = int'($urandom_range(0, 14));
        int op;
        case (sel)
            0, 1, 2: op = 0;
            3: op = 2;   4: op = 3;   5: op = 4;   6: op = 5;
            7: op = 8;   8: op = 12;  9: op = 13;  10: op = 14;
            11, 12: op = 35;
            13: op = 43;
            default: op = int'($urandom_range(0, 63));
        endcase
        if (op == 0)
            return rtype(rreg(), rreg(), rreg(), ($urandom_range(0, 4) == 0) ? 8 : 32);
        if (op == 2 || op == 3)
            return jtype(op, int'($urandom_range(0, 1023)));
        return itype(op, rreg(), rreg(), int'($urandom_range(0, 65535)));
    endfunction

    initial begin
        // rst v inst eq | st pcs fa fb se
        vt.push_back(mk(1, 1, jtype(2, 'h10),        0, 0, 2'b00, 2'b00, 2'b00, 1));
        vt.push_back(mk(0, 1, rtype(1, 2, 3, 32),    0, 0, 2'b00, 2'b00, 2'b00, 1));
        vt.push_back(mk(0, 1, itype(4, 3, 4, 8),     1, 1, 2'b00, 2'b00, 2'b00, 1));
        vt.push_back(mk(0, 1, itype(4, 3, 4, 8),     1, 0, 2'b10, 2'b10, 2'b00, 1));
        vt.push_back(mk(0, 1, rtype(3, 3, 9, 32),    1, 0, 2'b00, 2'b00, 2'b00, 1));
        vt.push_back(mk(0, 1, itype(35, 1, 5, 0),    0, 0, 2'b00, 2'b00, 2'b00, 1));
        vt.push_back(mk(0, 1, itype(5, 5, 0, 4),     0, 1, 2'b00, 2'b00, 2'b00, 1));
        vt.push_back(mk(0, 1, itype(5, 5, 0, 4),     0, 1, 2'b00, 2'b00, 2'b00, 1));
        vt.push_back(mk(0, 1, itype(5, 5, 0, 4),     0, 0, 2'b10, 2'b01, 2'b00, 1));
        vt.push_back(mk(0, 0, 32'd0,                 0, 0, 2'b00, 2'b00, 2'b00, 1));
        vt.push_back(mk(0, 1, itype(35, 2, 7, 4),    0, 0, 2'b00, 2'b00, 2'b00, 1));
        vt.push_back(mk(0, 1, rtype(7, 7, 8, 32),    0, 1, 2'b00, 2'b00, 2'b00, 1));
        vt.push_back(mk(0, 1, rtype(7, 7, 8, 32),    0, 0, 2'b00, 2'b00, 2'b00, 1));
        vt.push_back(mk(0, 0, 32'd0,                 0, 0, 2'b00, 2'b00, 2'b00, 1));
        vt.push_back(mk(0, 1, jtype(2, 'h10),        0, 0, 2'b01, 2'b00, 2'b00, 1));
        vt.push_back(mk(0, 1, itype(13, 1, 4, 3),    0, 0, 2'b00, 2'b00, 2'b00, 0));
        vt.push_back(mk(0, 1, jtype(3, 'h40),        0, 0, 2'b01, 2'b00, 2'b00, 1));
        vt.push_back(mk(0, 1, 32'd0,                 0, 0, 2'b00, 2'b00, 2'b00, 1));
        vt.push_back(mk(0, 1, 32'd0,                 0, 0, 2'b00, 2'b00, 2'b00, 1));
        vt.push_back(mk(0, 1, rtype(31, 0, 0, 8),    0, 0, 2'b11, 2'b01, 2'b00, 1));
        vt.push_back(mk(0, 1, itype(13, 0, 6, 5),    0, 0, 2'b00, 2'b00, 2'b00, 0));
        vt.push_back(mk(0, 1, itype(13, 0, 6, 5),    0, 0, 2'b00, 2'b00, 2'b00, 0));
        vt.push_back(mk(0, 1, itype(35, 6, 7, 0),    0, 0, 2'b00, 2'b00, 2'b00, 1));
        vt.push_back(mk(0, 1, rtype(7, 1, 8, 32),    0, 1, 2'b00, 2'b00, 2'b00, 1));
        vt.push_back(mk(1, 1, rtype(7, 1, 8, 32),    0, 0, 2'b00, 2'b00, 2'b00, 1));
        vt.push_back(mk(0, 1, rtype(7, 1, 8, 32),    0, 0, 2'b00, 2'b00, 2'b00, 1));
        vt.push_back(mk(0, 1, itype(12, 1, 2, 1),    0, 0, 2'b00, 2'b00, 2'b00, 0));
        vt.push_back(mk(0, 1, itype(14, 1, 2, 1),    0, 0, 2'b00, 2'b00, 2'b00, 0));
        vt.push_back(mk(0, 1, itype(8, 1, 2, 1),     0, 0, 2'b00, 2'b00, 2'b00, 1));
        vt.push_back(mk(0, 1, itype(4, 2, 2, 3),     1, 1, 2'b00, 2'b00, 2'b00, 1));
        vt.push_back(mk(0, 1, itype(4, 2, 2, 3),     1, 0, 2'b10, 2'b10, 2'b10, 1));
        vt.push_back(mk(0, 1, rtype(2, 2, 3, 32),    0, 0, 2'b00, 2'b00, 2'b00, 1));

        repeat (2) @(posedge clk);
        for (int i = 0; i < vt.size(); i++) begin
            @(posedge clk);
            #1;
            reset    = vt[i].rst;
            valid_id = vt[i].v;
            inst_id  = vt[i].inst;
            cmp_eq   = vt[i].eq;
            @(negedge clk);
            check($sformatf("vec%0d_ctl", i), ctl_act(), ctl_exp(vt[i].st, vt[i].pcs, vt[i].se));
            if (!vt[i].st)
                check($sformatf("vec%0d_fwd", i), {12'd0, forbranchA, forbranchB},
                      {12'd0, vt[i].fa, vt[i].fb});
        end

        @(posedge clk);
        #1;
        reset    = 1'b1;
        valid_id = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int a = 0; a < 3; a++) begin
            h_dst[a] = 5'd0;
            h_ld[a]  = 0;
        end
        kill_m = 0;

        for (int n = 0; n < 2000; n++) begin
            bit         rrs, rrt, br, ld, eff, st, sta, stb;
            logic [4:0] dst;
            logic [1:0] fa, fb, pcs;
            int         op;
            @(posedge clk);
            #1;
            valid_id = ($urandom_range(0, 9) != 0);
            inst_id  = rnd_inst();
            cmp_eq   = 1'($urandom_range(0, 1));

            mdec(inst_id, rrs, rrt, br, ld, dst);
            op  = int'(inst_id[31:26]);
            eff = valid_id && !kill_m;
            mop(rrs, inst_id[25:21], br, sta, fa);
            mop(rrt, inst_id[20:16], br, stb, fb);
            st  = eff && (sta || stb);
            pcs = 2'b00;
            if (eff && !st) begin
                if (op == 2 || op == 3)                      pcs = 2'b01;
                else if (op == 4 && cmp_eq)                  pcs = 2'b10;
                else if (op == 5 && !cmp_eq)                 pcs = 2'b10;
                else if (op == 0 && inst_id[5:0] == 6'd8)    pcs = 2'b11;
            end

            @(negedge clk);
            check($sformatf("rnd%0d_ctl", n), ctl_act(),
                  ctl_exp(st, pcs, !(op == 12 || op == 13 || op == 14)));
            if (!st)
                check($sformatf("rnd%0d_fwd", n), {12'd0, forbranchA, forbranchB},
                      eff ? {12'd0, fa, fb} : 16'd0);

            h_dst[2] = h_dst[1];
            h_ld[2]  = h_ld[1];
            h_dst[1] = h_dst[0];
            h_ld[1]  = h_ld[0];
            h_dst[0] = (eff && !st) ? dst : 5'd0;
            h_ld[0]  = eff && !st && ld;
            kill_m   = (pcs != 2'b00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
